seg_scan_decoder: RTL and testbench

Receive-side counterpart to the multiplexed seven-segment display driver. It samples the active-low anode and cathode scan lines and decodes each segment pattern back to a 4-bit digit value. When all eight digits have been captured, it publishes them as one coherent frame. It serves as an on-chip display readback monitor, either for self-check logic or for a bench that watches the display pins.

---
 rtl/seg_scan_decoder.sv | 147 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan readback: samples active-low anode/cathode lines,
// decodes digits, publishes 8-digit frames. Hex decode: SEG_DECODE_HEX_EN.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  an_in,
  input  logic [6:0]  seg_in,
  output logic [31:0] digits_out,
  output logic [7:0]  blank_out,
  output logic [7:0]  err_out,
  output logic        frame_valid,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]    an_s1, an_s2;
  logic [6:0]    seg_s1, seg_s2;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          sampled;
  logic [7:0]    seen;
  logic [31:0]   sh_dig;
  logic [7:0]    sh_blank;
  logic [7:0]    sh_err;
  logic          an_valid;
  logic          stable;
  logic          hit;
  logic          publish;
  logic [2:0]    idx;
  logic [5:0]    dec;

  // {blank, err, digit}
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'b1000000: r = 6'h00;
      7'b1111001: r = 6'h01;
      7'b0100100: r = 6'h02;
      7'b0110000: r = 6'h03;
      7'b0011001: r = 6'h04;
      7'b0010010: r = 6'h05;
      7'b0000010: r = 6'h06;
      7'b1111000: r = 6'h07;
      7'b0000000: r = 6'h08;
      7'b0011000: r = 6'h09;
`ifdef SEG_DECODE_HEX_EN
      7'b0001000: r = 6'h0A;
      7'b0000011: r = 6'h0B;
      7'b1000110: r = 6'h0C;
      7'b0100001: r = 6'h0D;
      7'b0000110: r = 6'h0E;
      7'b0001110: r = 6'h0F;
`endif
      7'b1111111: r = 6'h20;
      default:    r = 6'h10;
    endcase
    return r;
  endfunction

  // Stable means the synchronised value is about to hold for another cycle
  assign an_valid = $onehot(~an_s2);
  assign stable   = (an_s1 == an_s2) && (seg_s1 == seg_s2);
  assign hit      = an_valid && stable && !sampled &&
                    (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign publish  = (seen == 8'hFF);
  assign dec      = decode(seg_s2);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (!an_s2[i]) idx = 3'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1    <= '1;
      an_s2    <= '1;
      seg_s1   <= '1;
      seg_s2   <= '1;
      settle_cnt <= '0;
      sampled  <= 1'b0;
    end else begin
      an_s1  <= an_in;
      an_s2  <= an_s1;
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      if (!an_valid || !stable)
        settle_cnt <= '0;
      else if (settle_cnt != SW'(SETTLE_CYCLES))
        settle_cnt <= settle_cnt + SW'(1);
      if (!an_valid || an_s1 != an_s2)
        sampled <= 1'b0;
      else if (hit)
        sampled <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen     <= '0;
      sh_dig   <= '0;
      sh_blank <= '0;
      sh_err   <= '0;
    end else begin
      if (hit) begin
        sh_dig[idx*4 +: 4] <= dec[3:0];
        sh_err[idx]        <= dec[4];
        sh_blank[idx]      <= dec[5];
      end
      if (publish)
        seen <= hit ? (8'h01 << idx) : 8'h00;
      else if (hit)
        seen <= seen | (8'h01 << idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_out  <= '0;
      blank_out   <= 8'hFF;
      err_out     <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b1;
      tmo_cnt     <= '0;
    end else begin
      frame_valid <= publish;
      if (publish) begin
        digits_out <= sh_dig;
        blank_out  <= sh_blank;
        err_out    <= sh_err;
        tmo_cnt    <= '0;
        stale      <= 1'b0;
      end else begin
        if (tmo_cnt != TW'(TIMEOUT_CYCLES))
          tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))
          stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder.
// Short settle/timeout parameters keep runs small.
module tb_seg_scan_decoder;

  localparam int S  = 20;
  localparam int T  = 1500;
  localparam int DW = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  an_in;
  logic [6:0]  seg_in;
  logic [31:0] digits_out;
  logic [7:0]  blank_out;
  logic [7:0]  err_out;
  logic        frame_valid;
  logic        stale;

  seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .an_in(an_in), .seg_in(seg_in),
    .digits_out(digits_out), .blank_out(blank_out), .err_out(err_out),
    .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       blank;
    logic       err;
  } vec_t;

  vec_t       tv[16];
  logic [6:0] segs[10];
  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int fv_count = 0;
  int fv_cyc = 0;
  int rise_cyc = 0;
  logic stale_q = 1'b1;
  logic stale_at_fv = 1'b1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (frame_valid === 1'b1) begin
      fv_count = fv_count + 1;
      fv_cyc = cyc;
      stale_at_fv = stale;
    end
    if (stale === 1'b1 && stale_q === 1'b0) rise_cyc = cyc;
    stale_q = stale;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] a, input logic [6:0] s,
                     input int n);
    an_in = a;
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] an_of(input int i);
    logic [7:0] a;
    a = 8'hFF;
    a[i] = 1'b0;
    return a;
  endfunction

  task automatic run_tv_frame(input int base);
    for (int i = 0; i < 8; i++) put(an_of(i), tv[base+i].seg, DW);
  endtask

  task automatic check_tv_frame(input int base);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tv%0d_dig", base+i), 32'(digits_out[4*i +: 4]),
          32'(tv[base+i].dig));
      chk($sformatf("tv%0d_blank", base+i), 32'(blank_out[i]),
          32'(tv[base+i].blank));
      chk($sformatf("tv%0d_err", base+i), 32'(err_out[i]),
          32'(tv[base+i].err));
    end
  endtask

  initial begin
    int n0;
    int k;
    logic [31:0] exp_b;
    segs = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
             7'b0000000, 7'b0011000};
    tv[0]  = '{7'b1000000, 4'h0, 1'b0, 1'b0};
    tv[1]  = '{7'b0011000, 4'h9, 1'b0, 1'b0};
    tv[2]  = '{7'b0100100, 4'h2, 1'b0, 1'b0};
    tv[3]  = '{7'b0101010, 4'h0, 1'b0, 1'b1};
    tv[4]  = '{7'b0110000, 4'h3, 1'b0, 1'b0};
    tv[5]  = '{7'b0011001, 4'h4, 1'b0, 1'b0};
    tv[6]  = '{7'b0010010, 4'h5, 1'b0, 1'b0};
    tv[7]  = '{7'b1111111, 4'h0, 1'b1, 1'b0};
    tv[8]  = '{7'b0000010, 4'h6, 1'b0, 1'b0};
    tv[9]  = '{7'b1111000, 4'h7, 1'b0, 1'b0};
    tv[10] = '{7'b0000000, 4'h8, 1'b0, 1'b0};
`ifdef SEG_DECODE_HEX_EN
    tv[11] = '{7'b0001000, 4'hA, 1'b0, 1'b0};
    tv[12] = '{7'b0000011, 4'hB, 1'b0, 1'b0};
    tv[13] = '{7'b1000110, 4'hC, 1'b0, 1'b0};
    tv[14] = '{7'b0100001, 4'hD, 1'b0, 1'b0};
    tv[15] = '{7'b0001110, 4'hF, 1'b0, 1'b0};
`else
    tv[11] = '{7'b0001000, 4'h0, 1'b0, 1'b1};
    tv[12] = '{7'b0000011, 4'h0, 1'b0, 1'b1};
    tv[13] = '{7'b1000110, 4'h0, 1'b0, 1'b1};
    tv[14] = '{7'b0100001, 4'h0, 1'b0, 1'b1};
    tv[15] = '{7'b0001110, 4'h0, 1'b0, 1'b1};
`endif
    // frame B as it appears on digits 0..7
    exp_b = '0;
    for (int i = 0; i < 8; i++) exp_b[4*i +: 4] = tv[8+i].dig;

    rst_n = 1'b0;
    an_in = 8'hFF;
    seg_in = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", digits_out, 32'h0);
    chk("rst_blank", 32'(blank_out), 32'hFF);
    chk("rst_err", 32'(err_out), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_stale", 32'(stale), 32'h1);
    rst_n = 1'b1;

    // full frame of digits 1..8
    n0 = fv_count;
    for (int i = 0; i < 8; i++) put(an_of(i), segs[i+1], DW);
    chk("full_fv_count", 32'(fv_count - n0), 32'd1);
    chk("full_digits", digits_out, 32'h87654321);
    chk("full_blank", 32'(blank_out), 32'h0);
    chk("full_err", 32'(err_out), 32'h0);
    chk("full_stale", 32'(stale), 32'h0);

    // frame A: error on digit 3, blank on digit 7
    run_tv_frame(0);
    check_tv_frame(0);
    chk("fa_err_vec", 32'(err_out), 32'h08);
    chk("fa_blank_vec", 32'(blank_out), 32'h80);

    // frame B: upper digits and hex patterns
    run_tv_frame(8);
    check_tv_frame(8);
    chk("fb_stale", 32'(stale), 32'h0);

    // timeout with anodes idle
    put(8'hFF, 7'h7F, 0);
    k = 0;
    while (stale !== 1'b1 && k < 3 * T) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("tmo_stale", 32'(stale), 32'h1);
    chk("tmo_latency", 32'(rise_cyc - fv_cyc), 32'(T));
    chk("tmo_hold", digits_out, exp_b);

    // next frame clears stale together with frame_valid
    n0 = fv_count;
    for (int i = 0; i < 8; i++) put(an_of(i), segs[i+1], DW);
    chk("recov_fv_count", 32'(fv_count - n0), 32'd1);
    chk("recov_stale_at_fv", 32'(stale_at_fv), 32'h0);
    chk("recov_stale", 32'(stale), 32'h0);
    chk("recov_digits", digits_out, 32'h87654321);

    // unstable segments on anode 2
    for (int i = 0; i < 10; i++)
      put(8'hFB, (i % 2 == 0) ? segs[2] : segs[3], 10);
    chk("unstable_seen2", 32'(dut.seen[2]), 32'h0);
    put(8'hFB, segs[4], 0);
    k = 0;
    while (dut.seen[2] !== 1'b1 && k < 10 * S) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("settle_latency", 32'(k), 32'(S + 2));

    // two anodes low: nothing sampled
    put(8'b11110011, segs[5], 3 * S);
    chk("two_anode_seen", 32'(dut.seen), 32'h04);

    // reset mid-frame after four digits
    for (int i = 0; i < 4; i++) put(an_of(i), segs[i], DW);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", digits_out, 32'h0);
    chk("mid_rst_blank", 32'(blank_out), 32'hFF);
    chk("mid_rst_err", 32'(err_out), 32'h0);
    chk("mid_rst_stale", 32'(stale), 32'h1);
    chk("mid_rst_seen", 32'(dut.seen), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = fv_count;
    for (int i = 4; i < 8; i++) put(an_of(i), segs[8-i], DW);
    chk("half_frame_no_fv", 32'(fv_count - n0), 32'd0);
    for (int i = 0; i < 4; i++) put(an_of(i), segs[8-i], DW);
    chk("after_rst_fv", 32'(fv_count - n0), 32'd1);
    chk("after_rst_digits", digits_out, 32'h12345678);
    chk("after_rst_stale", 32'(stale), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
